// File: rtl/gray_display_pkg.sv
// ---------------------------------------------------------------------------
// gray_display_pkg
// Shared definitions for the Gray-code multiplexed 7-segment scanner.
//   - scan_state_t    : scanner FSM states (IDLE / SHOW / BLANK)
//   - SEG_A..SEG_G    : bit position of each segment on the output pins
//   - SEG_TABLE       : 16 hex glyphs (0-F), stored in a..g order (bit6=a)
//   - bin_to_gray     : 4-bit binary to Gray conversion
//   - glyph_to_pins   : maps an a..g glyph onto the pin bit order
// The BLANK state only becomes reachable when GRAY_SCAN_BLANK_EN is defined.
// ---------------------------------------------------------------------------
package gray_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Glyphs are written as abcdefg, left to right
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110,
    7'b0110000,
    7'b1101101,
    7'b1111001,
    7'b0110011,
    7'b1011011,
    7'b1011111,
    7'b1110000,
    7'b1111111,
    7'b1111011,
    7'b1110111,
    7'b0011111,
    7'b1001110,
    7'b0111101,
    7'b1001111,
    7'b1000111
  };

  function automatic logic [3:0] bin_to_gray(input logic [3:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Keeps the table readable while letting the pin order be changed in one place
  function automatic logic [6:0] glyph_to_pins(input logic [6:0] abcdefg);
    logic [6:0] pins;
    pins        = SEG_OFF;
    pins[SEG_A] = abcdefg[6];
    pins[SEG_B] = abcdefg[5];
    pins[SEG_C] = abcdefg[4];
    pins[SEG_D] = abcdefg[3];
    pins[SEG_E] = abcdefg[2];
    pins[SEG_F] = abcdefg[1];
    pins[SEG_G] = abcdefg[0];
    return pins;
  endfunction

endpackage

// File: rtl/gray_seg_decoder.sv
// ---------------------------------------------------------------------------
// gray_seg_decoder
// Combinational Gray-convert plus hex glyph lookup, shared by all digits.
// Ports:
//   i_bin : 4-bit binary digit value
//   o_seg : segments a..g (active-high) for the Gray code of i_bin
// ---------------------------------------------------------------------------
module gray_seg_decoder
  import gray_display_pkg::*;
(
  input  logic [3:0] i_bin,
  output logic [6:0] o_seg
);

  logic [3:0] w_gray;

  assign w_gray = bin_to_gray(i_bin);
  assign o_seg  = glyph_to_pins(SEG_TABLE[w_gray]);

endmodule

// File: rtl/gray_display_scanner.sv
// ---------------------------------------------------------------------------
// gray_display_scanner
// Time-multiplexed Gray-code 7-segment controller. Holds NUM_DIGITS 4-bit
// values and lights one digit at a time through a single shared decoder.
// New values arrive over valid/ready into a shadow register and are moved
// to the displayed (active) register only at a frame boundary, or at once
// while the scanner is idle.
//
// Build option: define GRAY_SCAN_BLANK_EN to insert BLANK_CYCLES dark cycles
// between digits (anti-ghosting). Without it digits switch back-to-back.
//
// Ports:
//   i_clk           : system clock, rising edge
//   i_rst_n         : asynchronous active-low reset
//   i_enable        : scan enable; low blanks the display and parks in IDLE
//   i_load_valid    : new value set offered
//   i_load_data     : digit i on bits [4i+3:4i]
//   o_load_ready    : shadow register free (registered)
//   o_seven_segment : segments a..g on bits 6..0, active-high (registered)
//   o_digit_en      : one-hot digit select, active-high (registered)
//   o_frame_done    : one-cycle pulse after the last digit's slot (registered)
// ---------------------------------------------------------------------------
module gray_display_scanner
  import gray_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_load_valid,
  input  logic [4*NUM_DIGITS-1:0] i_load_data,
  output logic                    o_load_ready,
  output logic [6:0]              o_seven_segment,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_frame_done
);

  // One counter serves both the lit slot and the dark gap
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int DIG_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
`ifdef GRAY_SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  scan_state_t             r_state;
  logic [DIG_W-1:0]        r_digit;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;
  logic                    r_load_ready;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic                    r_frame_done;

  scan_state_t             w_state_nxt;
  logic [DIG_W-1:0]        w_digit_nxt;
  logic [DIG_W-1:0]        w_digit_inc;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_wrap;
  logic                    w_xfer;
  logic                    w_apply;
  logic                    w_pending_nxt;
  logic [4*NUM_DIGITS-1:0] w_active_nxt;
  logic [3:0]              w_dec_bin;
  logic [6:0]              w_dec_seg;
  logic                    w_show_nxt;
  logic [NUM_DIGITS-1:0]   w_onehot_nxt;

  assign w_digit_inc = (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;

  // Next scan position. The outputs are registered from these values so the
  // segments and digit enable switch on the same edge as the state/digit.
  // A digit slot ends (and the frame may wrap) only when moving to the next
  // digit; with blanking that is the end of the dark gap.
  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_cnt_nxt   = r_cnt;
    w_wrap      = 1'b0;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_digit_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SHOW;
          w_digit_nxt = '0;
          w_cnt_nxt   = '0;
        end
        ST_SHOW: begin
          if (r_cnt == PRE_LAST) begin
            w_cnt_nxt = '0;
`ifdef GRAY_SCAN_BLANK_EN
            w_state_nxt = ST_BLANK;
`else
            w_state_nxt = ST_SHOW;
            w_digit_nxt = w_digit_inc;
            w_wrap      = (r_digit == DIG_LAST);
`endif
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`ifdef GRAY_SCAN_BLANK_EN
        ST_BLANK: begin
          if (r_cnt == BLK_LAST) begin
            w_state_nxt = ST_SHOW;
            w_digit_nxt = w_digit_inc;
            w_cnt_nxt   = '0;
            w_wrap      = (r_digit == DIG_LAST);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
          w_digit_nxt = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Handshake and shadow/active hand-off. Pending data moves to the active
  // register at a frame wrap, or on any clock spent in IDLE. A capture on
  // the same clock lands in the shadow after the old shadow has been copied,
  // so it stays pending for the following boundary.
  always_comb begin
    w_xfer        = i_load_valid && r_load_ready;
    w_apply       = r_pending && ((r_state == ST_IDLE) || w_wrap);
    w_pending_nxt = w_xfer || (r_pending && !w_apply);
    w_active_nxt  = w_apply ? r_shadow : r_active;
    w_dec_bin     = w_active_nxt[{w_digit_nxt, 2'b00} +: 4];
    w_show_nxt    = (w_state_nxt == ST_SHOW);
    w_onehot_nxt  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_digit_nxt;
  end

  gray_seg_decoder u_decoder (
    .i_bin (w_dec_bin),
    .o_seg (w_dec_seg)
  );

  // Single state register block: FSM position, data registers and all
  // outputs. Reset clears everything, including any pending load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_digit      <= '0;
      r_cnt        <= '0;
      r_active     <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_load_ready <= 1'b1;
      r_seg        <= SEG_OFF;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_digit      <= w_digit_nxt;
      r_cnt        <= w_cnt_nxt;
      r_active     <= w_active_nxt;
      if (w_xfer) begin
        r_shadow <= i_load_data;
      end
      r_pending    <= w_pending_nxt;
      r_load_ready <= !w_pending_nxt;
      r_frame_done <= w_wrap;
      r_seg        <= w_show_nxt ? w_dec_seg : SEG_OFF;
      r_digit_en   <= w_show_nxt ? w_onehot_nxt : '0;
    end
  end

  assign o_load_ready    = r_load_ready;
  assign o_seven_segment = r_seg;
  assign o_digit_en      = r_digit_en;
  assign o_frame_done    = r_frame_done;

endmodule

// File: tb/tb_gray_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_gray_display_scanner
// Directed, table-driven bench for gray_display_scanner with NUM_DIGITS=4,
// PRESCALE=4, BLANK_CYCLES=2. Slot length follows GRAY_SCAN_BLANK_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gray_display_scanner;

  localparam int NUM_DIGITS   = 4;
  localparam int PRESCALE     = 4;
  localparam int BLANK_CYCLES = 2;
`ifdef GRAY_SCAN_BLANK_EN
  localparam int  SLOT     = PRESCALE + BLANK_CYCLES;
  localparam bit  BLANKING = 1'b1;
`else
  localparam int  SLOT     = PRESCALE;
  localparam bit  BLANKING = 1'b0;
`endif

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] G6 = 7'b1011111;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] GD = 7'b0111101;
  localparam logic [6:0] GF = 7'b1000111;

  typedef struct {
    logic        en;
    logic        valid;
    logic [15:0] data;
    int          cycles;
    logic [6:0]  expSeg;
    logic [3:0]  expEn;
    logic        expReady;
    logic        expFd;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic        loadValid;
  logic [15:0] loadData;
  logic        loadReady;
  logic [6:0]  sevenSeg;
  logic [3:0]  digitEn;
  logic        frameDone;

  int   compared;
  int   mismatched;
  vec_t vecs[$];

  gray_display_scanner #(
    .NUM_DIGITS   (NUM_DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_enable        (enable),
    .i_load_valid    (loadValid),
    .i_load_data     (loadData),
    .o_load_ready    (loadReady),
    .o_seven_segment (sevenSeg),
    .o_digit_en      (digitEn),
    .o_frame_done    (frameDone)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBit(input string tag, input string what,
                          input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s %s: got %b expected %b", tag, what, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] expSeg,
                             input logic [3:0] expEn, input logic expReady,
                             input logic expFd);
    compared++;
    if (sevenSeg !== expSeg) begin
      mismatched++;
      $display("[TB] FAIL %s seven_segment: got %b expected %b", tag, sevenSeg, expSeg);
    end
    compared++;
    if (digitEn !== expEn) begin
      mismatched++;
      $display("[TB] FAIL %s digit_en: got %b expected %b", tag, digitEn, expEn);
    end
    checkBit(tag, "load_ready", loadReady, expReady);
    checkBit(tag, "frame_done", frameDone, expFd);
  endtask

  // load_valid is offered for the first clock of a record only
  task automatic applyStimulus(input vec_t v);
    enable    = v.en;
    loadValid = v.valid;
    loadData  = v.data;
    for (int c = 0; c < v.cycles; c++) begin
      step();
      loadValid = 1'b0;
    end
  endtask

  function automatic void addVec(input logic en, input logic valid,
                                 input logic [15:0] data, input int cycles,
                                 input logic [6:0] expSeg, input logic [3:0] expEn,
                                 input logic expReady, input logic expFd);
    vec_t v;
    v.en = en; v.valid = valid; v.data = data; v.cycles = cycles;
    v.expSeg = expSeg; v.expEn = expEn; v.expReady = expReady; v.expFd = expFd;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [6:0] midSeg;
    logic [3:0] midEn;
    int         fdCount;

    compared   = 0;
    mismatched = 0;
    rstN       = 1'b0;
    enable     = 1'b0;
    loadValid  = 1'b0;
    loadData   = '0;

    // Edge numbering below counts from the first enabled clock (edge 1)
    addVec(1, 0, 16'h0000, 1,            G0, 4'b0001, 1, 0);
    addVec(1, 0, 16'h0000, SLOT,         G0, 4'b0010, 1, 0);
    addVec(1, 1, 16'hFA62, 1,            G0, 4'b0010, 0, 0);
    addVec(1, 0, 16'h0000, 3*SLOT-1,     G3, 4'b0001, 1, 1);
    addVec(1, 0, 16'h0000, 1,            G3, 4'b0001, 1, 0);
    addVec(1, 0, 16'h0000, SLOT-1,       G5, 4'b0010, 1, 0);
    addVec(1, 0, 16'h0000, SLOT,         GF, 4'b0100, 1, 0);
    addVec(1, 0, 16'h0000, SLOT,         G8, 4'b1000, 1, 0);
    addVec(1, 0, 16'h0000, SLOT,         G3, 4'b0001, 1, 1);
    addVec(1, 1, 16'h1111, 1,            G3, 4'b0001, 0, 0);
    addVec(1, 1, 16'h3333, 1,            G3, 4'b0001, 0, 0);
    addVec(1, 0, 16'h0000, 4*SLOT-2,     G1, 4'b0001, 1, 1);
    midSeg = BLANKING ? 7'b0 : G1;
    midEn  = BLANKING ? 4'b0 : 4'b1000;
    addVec(1, 0, 16'h0000, 4*SLOT-1,     midSeg, midEn, 1, 0);
    addVec(1, 1, 16'h4444, 1,            G1, 4'b0001, 0, 1);
    addVec(1, 0, 16'h0000, 4*SLOT,       G6, 4'b0001, 1, 1);
    addVec(1, 0, 16'h0000, 1,            G6, 4'b0001, 1, 0);
    addVec(0, 0, 16'h0000, 1,            7'b0, 4'b0000, 1, 0);
    addVec(0, 0, 16'h0000, 3,            7'b0, 4'b0000, 1, 0);
    addVec(1, 0, 16'h0000, 1,            G6, 4'b0001, 1, 0);
    addVec(1, 0, 16'h0000, PRESCALE-1,   G6, 4'b0001, 1, 0);
    midSeg = BLANKING ? 7'b0 : G6;
    midEn  = BLANKING ? 4'b0 : 4'b0010;
    addVec(1, 0, 16'h0000, 1,            midSeg, midEn, 1, 0);
    addVec(0, 0, 16'h0000, 1,            7'b0, 4'b0000, 1, 0);
    addVec(0, 1, 16'h0009, 1,            7'b0, 4'b0000, 0, 0);
    addVec(0, 0, 16'h0000, 1,            7'b0, 4'b0000, 1, 0);
    addVec(1, 0, 16'h0000, 1,            GD, 4'b0001, 1, 0);

    $display("[TB] reset and idle checks");
    repeat (3) step();
    checkOutput("reset", 7'b0, 4'b0000, 1'b1, 1'b0);
    rstN = 1'b1;
    step();
    checkOutput("idle_after_reset", 7'b0, 4'b0000, 1'b1, 1'b0);

    $display("[TB] running %0d table vectors, slot=%0d", vecs.size(), SLOT);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expSeg, vecs[i].expEn,
                  vecs[i].expReady, vecs[i].expFd);
    end

    // Async reset in the dark gap (or mid-frame without blanking) with a load pending
    $display("[TB] asynchronous reset mid-frame");
    loadValid = 1'b1;
    loadData  = 16'h7777;
    step();
    loadValid = 1'b0;
    checkOutput("pend_before_rst", GD, 4'b0001, 1'b0, 1'b0);
    repeat (PRESCALE-1) step();
    midSeg = BLANKING ? 7'b0 : G0;
    midEn  = BLANKING ? 4'b0 : 4'b0010;
    checkOutput("gap_before_rst", midSeg, midEn, 1'b0, 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_rst", 7'b0, 4'b0000, 1'b1, 1'b0);
    step();
    enable = 1'b0;
    rstN   = 1'b1;
    step();
    enable = 1'b1;
    step();
    checkOutput("restart_after_rst", G0, 4'b0001, 1'b1, 1'b0);

    // Two frames: pending 7777 must be gone and frame_done must pulse once per wrap
    fdCount = 0;
    for (int c = 1; c <= 8*SLOT; c++) begin
      step();
      if (frameDone === 1'b1) fdCount++;
      if (c == 4*SLOT) checkOutput("wrap_after_rst", G0, 4'b0001, 1'b1, 1'b1);
    end
    compared++;
    if (fdCount != 2) begin
      mismatched++;
      $display("[TB] FAIL frame_done_count: got %0d expected 2", fdCount);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gray_display_scanner.md
# gray_display_scanner

Time-multiplexed display controller for the binary-to-Gray 7-segment path. It holds NUM_DIGITS 4-bit binary values and scans them one digit at a time through a single shared Gray-convert/segment-decode datapath, driving a one-hot digit enable. New values arrive over a valid/ready handshake and are applied only at frame boundaries, so the display never shows a mix of old and new values. It sits between the switch/register front end and the board's multiplexed 7-segment pins.

## Interface
- NUM_DIGITS, 4: digits scanned per frame (2..8).
- PRESCALE, 50000: clock cycles each digit is lit (≥2).
- BLANK_CYCLES, 16: all-off cycles between digits (≥1; used only with the blanking macro).
- clk  in  1: system clock, all logic on its rising edge.
- rst  in  1: asynchronous, active-low reset.
- enable  in  1: scan enable. Low blanks the display and parks the FSM.
- load_valid  in  1: a new value set is offered.
- load_data  in  4*NUM_DIGITS: binary values; digit i is bits [4i+3:4i].
- load_ready  out  1: the shadow register is free.
- seven_segment  out  7: segments a..g on bits 6..0, active-high.
- digit_en  out  NUM_DIGITS: one-hot active-high digit select.
- frame_done  out  1: one-cycle pulse after the last digit's slot ends.

## Operation
- Reset values: seven_segment=0, digit_en=0, load_ready=1, frame_done=0, FSM=IDLE, digit index=0, prescaler=0, active and shadow registers=0, pending=0.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE→SHOW(digit 0) on the first clock with enable=1.
  - SHOW→BLANK when the prescaler reaches PRESCALE-1 (macro on).
  - SHOW→SHOW(next digit) at the same point (macro off).
  - BLANK→SHOW(next digit) after BLANK_CYCLES.
  - Any state→IDLE on the clock after enable=0. This resets the prescaler and digit index. Pending data is kept.
- Digit index wraps from NUM_DIGITS-1 to 0. At the wrap, frame_done pulses for one cycle.
- Handshake: a transfer occurs on a clock where load_valid && load_ready.
  - On transfer, load_data is captured into the shadow register, pending is set, and load_ready drops the next cycle.
  - At the frame boundary (the wrap clock), if pending is set: shadow is copied to active, pending clears, and load_ready rises the next cycle.
  - A transfer and a frame boundary on the same clock: the boundary copies the old shadow first (if pending), then the new data is captured and stays pending. No data is lost.
  - While in IDLE, pending data is applied immediately on the next clock.
- Datapath: gray = b ^ (b >> 1) on the current digit's active value, then a hex glyph (0-F) on the segments.
- In SHOW, digit_en has exactly one bit set. In IDLE and BLANK, digit_en=0 and seven_segment=0.

## Timing
- All outputs are registered.
- seven_segment and digit_en change on the same clock edge as the state/digit change. They never show a segment pattern belonging to a different digit.
- Digit slot lengths:
  - Macro on: PRESCALE cycles lit, then BLANK_CYCLES dark.
  - Macro off: PRESCALE cycles.
- Frame length is NUM_DIGITS × slot length.
- Load-to-display latency is at most one frame plus one cycle.
- Reset asserted mid-frame clears everything immediately (asynchronous), with no frame_done pulse.

## Configuration
- GRAY_SCAN_BLANK_EN: when defined, the BLANK state and BLANK_CYCLES inter-digit dark gap are compiled in to suppress ghosting.
- When undefined, there is no BLANK state and digits switch back-to-back. BLANK_CYCLES is ignored.

## Structure
- Shared package `gray_display_pkg` holds:
  - the FSM state enum;
  - the 16-entry hex segment table;
  - the segment bit-order constants.
- Sub-module `gray_seg_decoder` (combinational): 4-bit binary in, 7-bit segments out (Gray conversion plus glyph lookup). It is instantiated once and shared across all digits.

## Test plan
Benches use NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2.
- Reset, then enable=1 with active values {0,0,0,0}: after one clock, digit_en=0001 and seven_segment=1111110 ('0'). Digit changes every 6 cycles with the macro on, every 4 with it off.
- Load load_data=16'hFA62 (digit0=2, digit1=6, digit2=A, digit3=F): after the next frame boundary the digits show 1111001 ('3'), 1011011 ('5'), 1000111 ('F'), 1111111 ('8').
- Second load while pending: load_ready=0, so no transfer occurs. load_ready returns to 1 one cycle after the boundary, and the second value is then accepted.
- Load on the exact wrap clock: the old pending value is displayed in the next frame, the new value is displayed in the frame after, and frame_done pulses exactly once per wrap.
- enable dropped mid-SHOW: next cycle digit_en=0 and seven_segment=0. On re-enable, the scan restarts at digit 0 with a full PRESCALE slot.
- rst pulsed low mid-BLANK: all outputs return to reset values immediately and load_ready=1. A pending load is discarded.
